spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- SPI shift engine downstream of the register/FIFO bridge.
- On a one-cycle transfer start pulse it pulls 32-bit words from the TX FIFO and shifts them out on MOSI, capturing MISO into 32-bit words that it pushes to the RX FIFO.
- Drives SCLK/SS_n per the latched control register and pulses transfer-done when the programmed word count completes.

Parameters:
- SS_WIDTH, 4, number of slave-select lines.
- DIV_WIDTH, 8, width of the SCLK half-period divider field.

Ports:
- clk_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- reg_control_i  in  32  [0] CPOL, [1] CPHA, [2] LSB-first, [15:8] clk_div, [19:16] ss_sel (one-hot mask)
- reg_trans_ctrl_i  in  32  [7:0] word_cnt_m1 (words = value+1); [13] start (edge-detected upstream, unused here)
- trans_start_i  in  1  one-cycle start pulse
- trans_done_o  out  1  one-cycle completion pulse
- tx_empty_i  in  1  TX FIFO empty
- tx_data_i  in  32  TX FIFO head word (first-word-fall-through)
- tx_pull_o  out  1  TX pop strobe
- rx_full_i  in  1  RX FIFO full
- rx_data_o  out  32  received word
- rx_push_o  out  1  RX push strobe
- sclk_o  out  1  SPI clock
- mosi_o  out  1  SPI data out
- miso_i  in  1  SPI data in
- ss_n_o  out  SS_WIDTH  active-low slave selects

Behaviour:
- Reset values: trans_done_o=0, tx_pull_o=0, rx_push_o=0, rx_data_o=0, sclk_o=0, mosi_o=0, ss_n_o=all 1. All state is cleared asynchronously.
- Configuration latch: when trans_start_i is seen in IDLE, latch CPOL, CPHA, LSB, clk_div, ss_sel and word count. trans_start_i in any other state is ignored.
- IDLE: sclk_o tracks reg_control_i[0] each cycle. ss_n_o is all 1.
- FSM states: IDLE, LOAD, SHIFT, STORE, DONE.
- IDLE -> LOAD on trans_start_i. ss_n_o = ~ss_sel from the next cycle and stays low until DONE.
- LOAD:
  - If tx_empty_i=1, stall; sclk_o holds at CPOL, no timeout.
  - Otherwise capture tx_data_i into the shift register and assert tx_pull_o for exactly 1 cycle.
  - Present the first bit on mosi_o (MSB, or LSB when LSB=1), then -> SHIFT.
- SHIFT:
  - Half-period counter reloads to clk_div; one SCLK edge occurs each (clk_div+1) clk_i cycles.
  - 64 edges per word; sclk_o toggles at each edge.
  - CPHA=0: sample miso_i on odd (leading) edges, shift the next mosi bit on even (trailing) edges, except after the 32nd bit.
  - CPHA=1: shift on leading edges, including the first; sample on trailing edges.
  - After the 64th edge sclk_o equals CPOL -> STORE.
- STORE:
  - If rx_full_i=1, stall (SCLK idle, ss held low).
  - Otherwise rx_data_o = captured word and rx_push_o=1 for 1 cycle.
  - If words remaining > 0: decrement, -> LOAD. Else -> DONE.
- DONE: ss_n_o returns to all 1, trans_done_o=1 for 1 cycle, -> IDLE.
- Bit order: MSB-first shifts left and fills the LSB with the sample; LSB-first mirrors this.
- Word counter: 8 bits, so the maximum is 256 words. clk_div=0 gives SCLK = clk_i/2.
- Simultaneous events: tx_pull_o and rx_push_o are never asserted in the same cycle. trans_done_o never coincides with rx_push_o.
- Reset mid-transfer aborts immediately: ss_n_o high, no done pulse, FIFO contents untouched.
- Unused FSM encodings return to IDLE with outputs at reset values.

Decomposition:
- Shared package spi_if_pkg holds:
  - FSM state localparams.
  - Control-register bit-position constants: CPOL=0, CPHA=1, LSB=2, DIV_LSB=8, SS_LSB=16.
  - Transfer-control word-count field position.
- One sub-module, spi_clk_gen: divider counter, edge strobes (lead/trail) and sclk_o generation; enabled by the FSM in SHIFT.

Test Plan:
- Mode 0, clk_div=1, 1 word, TX=0xA5A5_0F0F, MISO looped to MOSI -> 32 SCLK periods of 4 clk_i each; RX push 0xA5A5_0F0F; single trans_done_o pulse; ss_n_o=0b1110 for ss_sel=0b0001.
- Mode 3 (CPOL=1, CPHA=1), LSB-first, TX=0x0000_0001, MISO tied 1 -> sclk_o idles high, first MOSI bit 1, RX=0xFFFF_FFFF.
- word_cnt_m1=2 with 3 TX words preloaded -> exactly 3 tx_pull_o and 3 rx_push_o pulses, ss_n_o low continuously, done after the third push.
- TX empty at LOAD for 20 cycles, then word written -> no SCLK edges during stall; transfer completes correctly afterward.
- rx_full_i held high 10 cycles in STORE -> rx_push_o withheld until release; no lost data; a second trans_start_i during the transfer is ignored.
- reset_n_i asserted mid-SHIFT (bit 10) -> ss_n_o all 1, sclk_o 0, no done pulse; a fresh trans_start_i then runs normally.

Source files
------------

// File: rtl/spi_if_pkg.sv
// Shared definitions for the SPI master core: FSM states, control-register
// field positions and the bit-order helpers used by both shift registers.
package spi_if_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STORE = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    localparam int CTRL_CPOL    = 0;
    localparam int CTRL_CPHA    = 1;
    localparam int CTRL_LSB     = 2;
    localparam int CTRL_DIV_LSB = 8;
    localparam int CTRL_SS_LSB  = 16;

    localparam int TCTRL_WCNT_LSB   = 0;
    localparam int TCTRL_WCNT_WIDTH = 8;

    // Advance a shift register by one bit; the vacated end takes fill.
    function automatic logic [31:0] shift_word(input logic [31:0] w,
                                               input logic lsb_first,
                                               input logic fill);
        return lsb_first ? {fill, w[31:1]} : {w[30:0], fill};
    endfunction

    function automatic logic head_bit(input logic [31:0] w, input logic lsb_first);
        return lsb_first ? w[0] : w[31];
    endfunction

endpackage

// File: rtl/spi_master_core_clk_gen.sv
// SCLK generator: one SCLK edge every (div+1) clocks while enabled, with
// leading/trailing/last-edge strobes that coincide with the toggling cycle.
module spi_clk_gen #(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 en_i,
    input  logic                 cpol_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 sclk_o,
    output logic                 lead_o,
    output logic                 trail_o,
    output logic                 last_o
);

    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [5:0]           edge_cnt_reg;
    logic                 edge_w;

    assign edge_w  = en_i && (cnt_reg == '0);
    assign lead_o  = edge_w && !edge_cnt_reg[0];
    assign trail_o = edge_w && edge_cnt_reg[0];
    assign last_o  = edge_w && (edge_cnt_reg == 6'd63);

    // While disabled the counter is preloaded so the first edge of a word
    // lands exactly (div+1) cycles after the enable rises.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_reg      <= '0;
            edge_cnt_reg <= '0;
            sclk_o       <= 1'b0;
        end else if (!en_i) begin
            cnt_reg      <= div_i;
            edge_cnt_reg <= '0;
            sclk_o       <= cpol_i;
        end else if (edge_w) begin
            cnt_reg      <= div_i;
            edge_cnt_reg <= edge_cnt_reg + 6'd1;
            sclk_o       <= ~sclk_o;
        end else begin
            cnt_reg      <= cnt_reg - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// SPI shift engine: pulls words from the TX FIFO, shifts them out on MOSI
// while capturing MISO, pushes received words to the RX FIFO.
module spi_master_core
    import spi_if_pkg::*;
#(
    parameter int SS_WIDTH  = 4,
    parameter int DIV_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [31:0]         reg_control_i,
    input  logic [31:0]         reg_trans_ctrl_i,
    input  logic                trans_start_i,
    output logic                trans_done_o,
    input  logic                tx_empty_i,
    input  logic [31:0]         tx_data_i,
    output logic                tx_pull_o,
    input  logic                rx_full_i,
    output logic [31:0]         rx_data_o,
    output logic                rx_push_o,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic [SS_WIDTH-1:0] ss_n_o
);

    spi_state_e                  state_reg;
    logic                        cpol_reg;
    logic                        cpha_reg;
    logic                        lsb_reg;
    logic [DIV_WIDTH-1:0]        div_reg;
    logic [TCTRL_WCNT_WIDTH-1:0] words_left_reg;
    logic [31:0]                 tx_sh_reg;
    logic [31:0]                 rx_sh_reg;

    logic clk_en;
    logic clk_cpol;
    logic lead;
    logic trail;
    logic last_edge;
    logic shift_evt;
    logic sample_evt;
    logic unused_bits;

    assign unused_bits = ^{reg_trans_ctrl_i[31:8], reg_control_i[31:20], reg_control_i[7:3]};

    assign clk_en = (state_reg == ST_SHIFT);

    always_comb begin
        clk_cpol = 1'b0;
        case (state_reg)
            ST_IDLE:                            clk_cpol = reg_control_i[CTRL_CPOL];
            ST_LOAD, ST_SHIFT, ST_STORE, ST_DONE: clk_cpol = cpol_reg;
            default:                            clk_cpol = 1'b0;
        endcase
    end

    // CPHA=0 presents the first bit in LOAD, so its final trailing edge
    // must not shift; CPHA=1 presents every bit on a leading edge.
    assign shift_evt  = cpha_reg ? lead : (trail && !last_edge);
    assign sample_evt = cpha_reg ? trail : lead;

    spi_clk_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_clk_gen (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (clk_en),
        .cpol_i   (clk_cpol),
        .div_i    (div_reg),
        .sclk_o   (sclk_o),
        .lead_o   (lead),
        .trail_o  (trail),
        .last_o   (last_edge)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg      <= ST_IDLE;
            cpol_reg       <= 1'b0;
            cpha_reg       <= 1'b0;
            lsb_reg        <= 1'b0;
            div_reg        <= '0;
            words_left_reg <= '0;
            tx_sh_reg      <= '0;
            rx_sh_reg      <= '0;
            trans_done_o   <= 1'b0;
            tx_pull_o      <= 1'b0;
            rx_push_o      <= 1'b0;
            rx_data_o      <= '0;
            mosi_o         <= 1'b0;
            ss_n_o         <= '1;
        end else begin
            trans_done_o <= 1'b0;
            tx_pull_o    <= 1'b0;
            rx_push_o    <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    ss_n_o <= '1;
                    if (trans_start_i) begin
                        cpol_reg       <= reg_control_i[CTRL_CPOL];
                        cpha_reg       <= reg_control_i[CTRL_CPHA];
                        lsb_reg        <= reg_control_i[CTRL_LSB];
                        div_reg        <= reg_control_i[CTRL_DIV_LSB +: DIV_WIDTH];
                        words_left_reg <= reg_trans_ctrl_i[TCTRL_WCNT_LSB +: TCTRL_WCNT_WIDTH];
                        ss_n_o         <= ~reg_control_i[CTRL_SS_LSB +: SS_WIDTH];
                        state_reg      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (!tx_empty_i) begin
                        tx_pull_o <= 1'b1;
                        mosi_o    <= head_bit(tx_data_i, lsb_reg);
                        tx_sh_reg <= cpha_reg ? tx_data_i : shift_word(tx_data_i, lsb_reg, 1'b0);
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (shift_evt) begin
                        mosi_o    <= head_bit(tx_sh_reg, lsb_reg);
                        tx_sh_reg <= shift_word(tx_sh_reg, lsb_reg, 1'b0);
                    end
                    if (sample_evt) begin
                        rx_sh_reg <= shift_word(rx_sh_reg, lsb_reg, miso_i);
                    end
                    if (last_edge) begin
                        state_reg <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (!rx_full_i) begin
                        rx_data_o <= rx_sh_reg;
                        rx_push_o <= 1'b1;
                        if (words_left_reg != '0) begin
                            words_left_reg <= words_left_reg - 1'b1;
                            state_reg      <= ST_LOAD;
                        end else begin
                            state_reg      <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    ss_n_o       <= '1;
                    trans_done_o <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    rx_data_o <= '0;
                    mosi_o    <= 1'b0;
                    ss_n_o    <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: FIFO models, RX scoreboard,
// a table of single-word transfers plus hand-written corner sequences.
module tb_spi_master_core;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [31:0] reg_control_i = '0;
    logic [31:0] reg_trans_ctrl_i = '0;
    logic        trans_start_i = 1'b0;
    logic        trans_done_o;
    logic        tx_empty_i = 1'b1;
    logic [31:0] tx_data_i = '0;
    logic        tx_pull_o;
    logic        rx_full_i = 1'b0;
    logic [31:0] rx_data_o;
    logic        rx_push_o;
    logic        sclk_o;
    logic        mosi_o;
    logic        miso_i;
    logic [3:0]  ss_n_o;

    spi_master_core #(.SS_WIDTH(4), .DIV_WIDTH(8)) dut (
        .clk_i           (clk_i),
        .reset_n_i       (reset_n_i),
        .reg_control_i   (reg_control_i),
        .reg_trans_ctrl_i(reg_trans_ctrl_i),
        .trans_start_i   (trans_start_i),
        .trans_done_o    (trans_done_o),
        .tx_empty_i      (tx_empty_i),
        .tx_data_i       (tx_data_i),
        .tx_pull_o       (tx_pull_o),
        .rx_full_i       (rx_full_i),
        .rx_data_o       (rx_data_o),
        .rx_push_o       (rx_push_o),
        .sclk_o          (sclk_o),
        .mosi_o          (mosi_o),
        .miso_i          (miso_i),
        .ss_n_o          (ss_n_o)
    );

    always #5 clk_i = ~clk_i;

    // 0: MISO looped back from MOSI, 1: tied high, 2: tied low
    int miso_mode = 0;
    assign miso_i = (miso_mode == 0) ? mosi_o : ((miso_mode == 1) ? 1'b1 : 1'b0);

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] tx;
        int          miso;
        logic [31:0] exp_rx;
        logic        exp_first;
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] tx_q[$];
    logic [31:0] exp_q[$];

    int   cyc = 0;
    int   n_edges, n_pull, n_push, n_done, n_ss_rise, n_viol, push_at_done;
    int   first_edge_cyc, last_edge_cyc;
    logic first_mosi;
    logic sclk_prev = 1'b0;
    logic [3:0] ss_prev = 4'hF;
    logic [3:0] ss_exp = 4'hF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Monitor, FIFO models and scoreboard, all sampled on the falling edge.
    always @(negedge clk_i) begin
        cyc++;
        if (reset_n_i) begin
            if (sclk_o !== sclk_prev && ss_n_o != 4'hF) begin
                n_edges++;
                if (first_edge_cyc < 0) first_edge_cyc = cyc;
                last_edge_cyc = cyc;
            end
            if (tx_pull_o) begin
                if (n_pull == 0) first_mosi = mosi_o;
                n_pull++;
                if (tx_q.size() > 0) void'(tx_q.pop_front());
            end
            if (rx_push_o) begin
                n_push++;
                if (exp_q.size() == 0) check("rx_unexpected_push", rx_data_o, 32'hXXXX_XXXX);
                else check("rx_word", rx_data_o, exp_q.pop_front());
            end
            if (trans_done_o) begin
                n_done++;
                push_at_done = n_push;
            end
            if (tx_pull_o && rx_push_o) n_viol++;
            if (trans_done_o && rx_push_o) n_viol++;
            if (ss_n_o != 4'hF && ss_n_o != ss_exp) n_viol++;
            if (ss_prev != 4'hF && ss_n_o == 4'hF) n_ss_rise++;
        end
        sclk_prev  = sclk_o;
        ss_prev    = ss_n_o;
        tx_empty_i = (tx_q.size() == 0);
        tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
    end

    task automatic clear_counts();
        n_edges = 0; n_pull = 0; n_push = 0; n_done = 0; n_ss_rise = 0;
        n_viol = 0; push_at_done = -1; first_edge_cyc = -1; last_edge_cyc = -1;
        first_mosi = 1'bx;
    endtask

    task automatic pulse_start(input logic [31:0] ctrl, input logic [7:0] wcnt_m1);
        @(negedge clk_i);
        reg_control_i    = ctrl;
        reg_trans_ctrl_i = {18'h0, 1'b1, 5'h0, wcnt_m1};
        ss_exp           = ~ctrl[19:16];
        trans_start_i    = 1'b1;
        @(negedge clk_i);
        trans_start_i    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (n_done == 0 && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("done_within_budget", (n_done != 0), 1);
    endtask

    task automatic wait_edges(input int target, input int budget);
        int i;
        i = 0;
        while (n_edges < target && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("edges_within_budget", (n_edges >= target), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int div;
        div = int'(v.ctrl[15:8]);
        @(negedge clk_i);
        reg_control_i = v.ctrl;
        miso_mode     = v.miso;
        repeat (2) @(negedge clk_i);
        check("idle_sclk_tracks_cpol", sclk_o, v.ctrl[0]);
        clear_counts();
        tx_q.push_back(v.tx);
        exp_q.push_back(v.exp_rx);
        pulse_start(v.ctrl, 8'd0);
        wait_done(64 * (div + 1) + 200);
        repeat (3) @(negedge clk_i);
        check("edge_count", n_edges, 64);
        check("edge_span", last_edge_cyc - first_edge_cyc, 63 * (div + 1));
        check("first_mosi", first_mosi, v.exp_first);
        check("pull_count", n_pull, 1);
        check("push_count", n_push, 1);
        check("done_count", n_done, 1);
        check("overlap_or_ss", n_viol, 0);
        check("ss_released", ss_n_o, 4'hF);
        check("sclk_idle_after", sclk_o, v.ctrl[0]);
        $display("xfer %0d: ctrl=%h tx=%h exp_rx=%h edges=%0d pushes=%0d",
                 idx, v.ctrl, v.tx, v.exp_rx, n_edges, n_push);
    endtask

    initial begin
        vecs[0] = '{32'h0001_0100, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F, 1'b1};
        vecs[1] = '{32'h0002_0107, 32'h0000_0001, 1, 32'hFFFF_FFFF, 1'b1};
        vecs[2] = '{32'h0004_0002, 32'h8000_0001, 0, 32'h8000_0001, 1'b1};
        vecs[3] = '{32'h0008_0205, 32'h1234_5678, 0, 32'h1234_5678, 1'b0};
        vecs[4] = '{32'h0003_0004, 32'hDEAD_BEEF, 2, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0001_0302, 32'h7FFF_FFFE, 1, 32'hFFFF_FFFF, 1'b0};
        clear_counts();

        // Reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_done", trans_done_o, 0);
        check("rst_pull", tx_pull_o, 0);
        check("rst_push", rx_push_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_sclk", sclk_o, 0);
        check("rst_mosi", mosi_o, 0);
        check("rst_ss", ss_n_o, 4'hF);
        reset_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Three words back to back, slave select held throughout
        clear_counts();
        miso_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tx_q.push_back(32'h1357_9BDF ^ (32'h0F0F_1111 * (i + 1)));
            exp_q.push_back(32'h1357_9BDF ^ (32'h0F0F_1111 * (i + 1)));
        end
        pulse_start(32'h0001_0000, 8'd2);
        wait_done(1000);
        repeat (3) @(negedge clk_i);
        check("multi_pull", n_pull, 3);
        check("multi_push", n_push, 3);
        check("multi_push_at_done", push_at_done, 3);
        check("multi_edges", n_edges, 192);
        check("multi_ss_rises", n_ss_rise, 1);
        check("multi_viol", n_viol, 0);
        $display("xfer multi: words=3 pulls=%0d pushes=%0d", n_pull, n_push);

        // TX empty in LOAD: no clock activity until a word arrives
        clear_counts();
        pulse_start(32'h0001_0100, 8'd0);
        repeat (20) @(negedge clk_i);
        check("stall_no_edges", n_edges, 0);
        check("stall_sclk", sclk_o, 0);
        check("stall_ss", ss_n_o, 4'hE);
        check("stall_no_pull", n_pull, 0);
        tx_q.push_back(32'hC3C3_5A5A);
        exp_q.push_back(32'hC3C3_5A5A);
        wait_done(500);
        repeat (3) @(negedge clk_i);
        check("stall_push", n_push, 1);
        check("stall_edges", n_edges, 64);
        $display("xfer tx_stall: pushes=%0d edges=%0d", n_push, n_edges);

        // RX full in STORE, with a stray start pulse during the transfer
        clear_counts();
        rx_full_i = 1'b1;
        tx_q.push_back(32'h6B6B_9494);
        exp_q.push_back(32'h6B6B_9494);
        pulse_start(32'h0001_0000, 8'd0);
        wait_edges(64, 500);
        repeat (4) @(negedge clk_i);
        trans_start_i = 1'b1;
        @(negedge clk_i);
        trans_start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("rxfull_withheld", n_push, 0);
        check("rxfull_ss_low", ss_n_o, 4'hE);
        rx_full_i = 1'b0;
        wait_done(100);
        repeat (10) @(negedge clk_i);
        check("rxfull_push", n_push, 1);
        check("rxfull_single_done", n_done, 1);
        check("stray_start_ignored", ss_n_o, 4'hF);
        check("stray_no_pull", n_pull, 1);
        $display("xfer rx_full: pushes=%0d dones=%0d", n_push, n_done);

        // Reset in the middle of a word
        clear_counts();
        tx_q.push_back(32'hFACE_0FF1);
        exp_q.push_back(32'hFACE_0FF1);
        pulse_start(32'h0001_0101, 8'd0);
        wait_edges(20, 500);
        reset_n_i = 1'b0;
        #1;
        check("abort_ss", ss_n_o, 4'hF);
        check("abort_sclk", sclk_o, 0);
        check("abort_mosi", mosi_o, 0);
        exp_q.delete();
        tx_q.delete();
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (20) @(negedge clk_i);
        check("abort_no_done", n_done, 0);
        check("abort_ss_idle", ss_n_o, 4'hF);
        $display("xfer reset_abort: edges_before_reset=%0d dones=%0d", n_edges, n_done);

        run_vec(vecs[0], 6);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
